// File: rtl/mem_port_arbiter_if.sv
// Request/response port between one memory master and mem_port_arbiter.
// One instance per master; the arbiter takes the slave side.
interface mem_port_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous SRAM, with
// address-window/alignment decode and a saturating contention counter.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave m0,
    mem_port_arbiter_if.slave m1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       conflict_cnt
);

    // Window size in bytes; one extra bit so ADDR_W up to 30 still compares correctly.
    localparam logic [32:0] WinBytes = 33'(4) << ADDR_W;

    logic        prio_q, prio_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_owner_q, rsp_owner_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_is_read_q, rsp_is_read_d;
    logic [15:0] conflict_q, conflict_d;

    logic        both_req, gnt_any, gnt_idx;
    logic        sel_we, in_win, aligned, acc_ok;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr, sel_wdata, off;
    logic [31:0] rsp_rdata;

    always_comb begin
        both_req  = m0.req & m1.req;
        gnt_any   = !reset && (m0.req || m1.req);
        gnt_idx   = both_req ? prio_q : m1.req;

        sel_we    = gnt_idx ? m1.we    : m0.we;
        sel_be    = gnt_idx ? m1.be    : m0.be;
        sel_addr  = gnt_idx ? m1.addr  : m0.addr;
        sel_wdata = gnt_idx ? m1.wdata : m0.wdata;

        // Addresses below BASE_ADDR wrap to a huge offset and fall out of the window.
        off       = sel_addr - BASE_ADDR;
        in_win    = {1'b0, off} < WinBytes;
        aligned   = sel_addr[1:0] == 2'b00;
        acc_ok    = gnt_any && in_win && aligned;

        m0.gnt    = gnt_any && !gnt_idx;
        m1.gnt    = gnt_any && gnt_idx;

        mem_en    = acc_ok;
        mem_we    = acc_ok && sel_we;
        mem_be    = acc_ok ? sel_be : 4'b0000;
        mem_addr  = acc_ok ? off[ADDR_W+1:2] : '0;
        mem_wdata = acc_ok ? sel_wdata : 32'h0;

        prio_d        = gnt_any ? ~gnt_idx : prio_q;
        rsp_valid_d   = gnt_any;
        rsp_owner_d   = gnt_idx;
        rsp_err_d     = !(in_win && aligned);
        rsp_is_read_d = !sel_we;
        conflict_d    = (both_req && conflict_q != 16'hFFFF) ? conflict_q + 16'd1 : conflict_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_owner_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_is_read_q <= 1'b0;
            conflict_q    <= 16'h0;
        end else begin
            prio_q        <= prio_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_owner_q   <= rsp_owner_d;
            rsp_err_q     <= rsp_err_d;
            rsp_is_read_q <= rsp_is_read_d;
            conflict_q    <= conflict_d;
        end
    end

    // A pending response is suppressed while reset is held so it is never seen.
    always_comb begin
        rsp_rdata = (rsp_is_read_q && !rsp_err_q) ? mem_rdata : 32'h0;

        m0.rvalid = !reset && rsp_valid_q && !rsp_owner_q;
        m1.rvalid = !reset && rsp_valid_q && rsp_owner_q;
        m0.err    = m0.rvalid && rsp_err_q;
        m1.err    = m1.rvalid && rsp_err_q;
        m0.rdata  = m0.rvalid ? rsp_rdata : 32'h0;
        m1.rdata  = m1.rvalid ? rsp_rdata : 32'h0;

        conflict_cnt = conflict_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] sram [1024];

    mem_port_arbiter_if i_m0 ();
    mem_port_arbiter_if i_m1 ();

    mem_port_arbiter #(
        .ADDR_W   (10),
        .BASE_ADDR(32'h0000_1000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0          (i_m0),
        .m1          (i_m1),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // SRAM contents are (re)loaded during reset so the model has a single writer.
    always @(posedge clk) begin
        if (reset) begin
            sram[0]    <= 32'h1111_1111;
            sram[1]    <= 32'hDEAD_BEEF;
            sram[2]    <= 32'h1122_3344;
            sram[1023] <= 32'hCAFE_F00D;
            mem_rdata  <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one full cycle; inputs are driven and outputs checked just after negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv0(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
        i_m0.req = req; i_m0.we = we; i_m0.be = be; i_m0.addr = addr; i_m0.wdata = wdata;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
        i_m1.req = req; i_m1.we = we; i_m1.be = be; i_m1.addr = addr; i_m1.wdata = wdata;
    endtask

    logic [31:0] err_addrs [3];

    initial begin
        err_addrs[0] = 32'h0000_1002;
        err_addrs[1] = 32'h0000_0FFC;
        err_addrs[2] = 32'h0000_2000;

        // Reset with both masters requesting: nothing may be granted.
        reset = 1'b1;
        drv0(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
        drv1(1'b1, 1'b0, 4'hF, 32'h1004, 32'h0);
        cyc();
        cyc();
        #1;
        chk("rst_gnt0", 32'(i_m0.gnt), 32'd0);
        chk("rst_gnt1", 32'(i_m1.gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rvalid0", 32'(i_m0.rvalid), 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);

        // Contention for 4 cycles: m0, m1, m0, m1.
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_gnt0", 32'(i_m0.gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_gnt1", 32'(i_m1.gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("cont_addr", 32'(mem_addr), (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k > 0) begin
                chk("cont_rv0", 32'(i_m0.rvalid), (k % 2 == 1) ? 32'd1 : 32'd0);
                chk("cont_rv1", 32'(i_m1.rvalid), (k % 2 == 0) ? 32'd1 : 32'd0);
                chk("cont_rdata", (k % 2 == 1) ? i_m0.rdata : i_m1.rdata,
                    (k % 2 == 1) ? 32'h1111_1111 : 32'hDEAD_BEEF);
            end
            cyc();
        end
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("cont_last_rv1", 32'(i_m1.rvalid), 32'd1);
        chk("cont_last_rd1", i_m1.rdata, 32'hDEAD_BEEF);
        chk("cont_last_rv0", 32'(i_m0.rvalid), 32'd0);
        chk("cont_cnt", 32'(conflict_cnt), 32'd4);

        // Single read from m0.
        cyc();
        drv0(1'b1, 1'b0, 4'hF, 32'h1004, 32'h0);
        #1;
        chk("rd_gnt0", 32'(i_m0.gnt), 32'd1);
        chk("rd_mem_en", 32'(mem_en), 32'd1);
        chk("rd_addr", 32'(mem_addr), 32'd1);
        cyc();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("rd_rv0", 32'(i_m0.rvalid), 32'd1);
        chk("rd_data", i_m0.rdata, 32'hDEAD_BEEF);
        chk("rd_err", 32'(i_m0.err), 32'd0);

        // Byte write from m1, then m0 reads it back.
        cyc();
        drv1(1'b1, 1'b1, 4'b0010, 32'h1008, 32'h0000_AB00);
        #1;
        chk("wr_gnt1", 32'(i_m1.gnt), 32'd1);
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_be", 32'(mem_be), 32'h2);
        chk("wr_addr", 32'(mem_addr), 32'd2);
        chk("wr_wdata", mem_wdata, 32'h0000_AB00);
        cyc();
        drv1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv0(1'b1, 1'b0, 4'hF, 32'h1008, 32'h0);
        #1;
        chk("wr_rv1", 32'(i_m1.rvalid), 32'd1);
        chk("wr_rdata", i_m1.rdata, 32'h0);
        chk("wr_err", 32'(i_m1.err), 32'd0);
        chk("rb_gnt0", 32'(i_m0.gnt), 32'd1);
        cyc();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("rb_rv0", 32'(i_m0.rvalid), 32'd1);
        chk("rb_data", i_m0.rdata, 32'h1122_AB44);

        // Misaligned, below-window and above-window accesses.
        for (int e = 0; e < 3; e++) begin
            cyc();
            drv0(1'b1, 1'b0, 4'hF, err_addrs[e], 32'h0);
            #1;
            chk("err_gnt0", 32'(i_m0.gnt), 32'd1);
            chk("err_mem_en", 32'(mem_en), 32'd0);
            chk("err_mem_addr", 32'(mem_addr), 32'd0);
            cyc();
            drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            #1;
            chk("err_rv0", 32'(i_m0.rvalid), 32'd1);
            chk("err_flag", 32'(i_m0.err), 32'd1);
            chk("err_rdata", i_m0.rdata, 32'h0);
        end

        // Last word of the window.
        cyc();
        drv0(1'b1, 1'b0, 4'hF, 32'h1FFC, 32'h0);
        #1;
        chk("edge_mem_en", 32'(mem_en), 32'd1);
        chk("edge_addr", 32'(mem_addr), 32'd1023);
        cyc();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("edge_err", 32'(i_m0.err), 32'd0);
        chk("edge_rdata", i_m0.rdata, 32'hCAFE_F00D);

        // Reset during a pending read response; prio left pointing at m1 beforehand.
        cyc();
        drv0(1'b1, 1'b0, 4'hF, 32'h1004, 32'h0);
        #1;
        chk("pre_gnt0", 32'(i_m0.gnt), 32'd1);
        cyc();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        chk("rstp_rv0", 32'(i_m0.rvalid), 32'd0);
        chk("rstp_rd0", i_m0.rdata, 32'h0);
        cyc();
        reset = 1'b0;
        drv0(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
        drv1(1'b1, 1'b0, 4'hF, 32'h1004, 32'h0);
        #1;
        chk("post_rv0", 32'(i_m0.rvalid), 32'd0);
        chk("post_cnt", 32'(conflict_cnt), 32'd0);
        chk("post_gnt0", 32'(i_m0.gnt), 32'd1);
        chk("post_gnt1", 32'(i_m1.gnt), 32'd0);
        cyc();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("post_cnt1", 32'(conflict_cnt), 32'd1);
        chk("post_rd0", i_m0.rdata, 32'h1111_1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
